// File: rtl/seq_lock_n_pkg.sv
// seq_lock_pkg: shared definitions for the seq_lock_n combination lock.
//   lock_state_t  - FSM state encoding (ENTRY, PROG, OPEN, LOCKOUT)
//   LED_*         - bit positions inside the 4-bit status LED bus
//   clog2()       - ceiling log2 with a floor of 1, used to size counters
package seq_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        PROG    = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_t;

    localparam int LED_LOCKOUT = 3;
    localparam int LED_PROG    = 2;
    localparam int LED_Z       = 1;
    localparam int LED_ERR     = 0;

    // Never returns 0 so that every derived vector is at least one bit wide.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_lock_n_if.sv
// seq_lock_n_if: board-side signals of the combination lock.
//   key        - active-low pushbuttons (1 = released)
//   passkey    - program-mode switch, active-high
//   Z          - unlock actuator drive
//   Led        - {lockout, prog_mode, Z, seq_err}
//   digit_idx  - digits entered/programmed in the current sequence
//   fail_cnt   - consecutive failed sequences
// master: the board/stimulus side; slave: the lock itself.
interface seq_lock_n_if
    import seq_lock_pkg::*;
#(
    parameter int NKEYS     = 4,
    parameter int SEQ_LEN   = 4,
    parameter int MAX_FAILS = 3
);
    logic [NKEYS-1:0]                  key;
    logic                              passkey;
    logic                              Z;
    logic [3:0]                        Led;
    logic [clog2(SEQ_LEN+1)-1:0]       digit_idx;
    logic [clog2(MAX_FAILS+1)-1:0]     fail_cnt;

    modport master (output key, passkey, input Z, Led, digit_idx, fail_cnt);
    modport slave  (input key, passkey, output Z, Led, digit_idx, fail_cnt);
endinterface

// File: rtl/seq_lock_n_tick_gen.sv
// lock_tick_gen: prescaler plus tick counter shared by the OPEN and
// LOCKOUT windows.
//   clk, reset - system clock, synchronous active-low reset
//   restart    - hold counters at zero (asserted while no window is timed)
//   limit      - number of ticks the current window lasts (>=1)
//   done       - one-cycle pulse on the last cycle of the window
module lock_tick_gen
    import seq_lock_pkg::*;
#(
    parameter  int DIV  = 1,
    parameter  int TMAX = 1,
    localparam int LW   = clog2(TMAX+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic [LW-1:0] limit,
    output logic          done
);
    localparam int PW = clog2(DIV);

    logic [PW-1:0] pre;
    logic [LW-1:0] tcnt;
    logic          tick;

    assign tick = (pre == PW'(DIV-1));
    // done fires in the cycle whose closing edge ends the window.
    assign done = tick && (tcnt == limit - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            pre  <= '0;
            tcnt <= '0;
        end else if (tick) begin
            pre  <= '0;
            tcnt <= tcnt + 1'b1;
        end else begin
            pre  <= pre + 1'b1;
        end
    end
endmodule

// File: rtl/seq_lock_n.sv
// seq_lock_n: parametrised programmable combination lock.
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low
//   bus    - seq_lock_n_if.slave (key, passkey in; Z, Led, digit_idx,
//            fail_cnt out)
// Optional build macro SEQ_LOCK_KEY_RELOCK_EN: any valid press while OPEN
// closes the unlock window early.
module seq_lock_n
    import seq_lock_pkg::*;
#(
    parameter int NKEYS         = 4,
    parameter int SEQ_LEN       = 4,
    parameter int MAX_FAILS     = 3,
    parameter int TIMER1        = 10,
    parameter int TIMER2        = 5,
    parameter int CLK_FREQUENCY = 50000000,
    parameter int TICK_HZ       = 1
) (
    input  logic         clk,
    input  logic         reset,
    seq_lock_n_if.slave  bus
);
    localparam int DW   = clog2(NKEYS);
    localparam int IW   = clog2(SEQ_LEN+1);
    localparam int FW   = clog2(MAX_FAILS+1);
    localparam int DIV  = CLK_FREQUENCY / TICK_HZ;
    localparam int TMAX = (TIMER1 > TIMER2) ? TIMER1 : TIMER2;
    localparam int LW   = clog2(TMAX+1);

    lock_state_t       state;
    logic [NKEYS-1:0]  key_q, key_d;
    logic              z_r, seq_err;
    logic [IW-1:0]     digit_idx;
    logic [FW-1:0]     fail_cnt;
    logic [DW-1:0]     code [SEQ_LEN];

    logic              press, valid, bad, last, done, relock;
    logic [DW-1:0]     digit, exp_digit;
    logic [3:0]        led;

    // A press is the first cycle a key appears after all were released.
    assign press = (key_d == '1) && (key_q != '1);
    assign valid = ($countones(~key_q) == 1);
    assign last  = (digit_idx == IW'(SEQ_LEN-1));
    assign bad   = !valid || (digit != exp_digit);

`ifdef SEQ_LOCK_KEY_RELOCK_EN
    assign relock = press && valid;
`else
    assign relock = 1'b0;
`endif

    always_comb begin
        digit     = '0;
        exp_digit = '0;
        for (int i = 0; i < NKEYS; i++)
            if (!key_q[i]) digit = DW'(i);
        for (int i = 0; i < SEQ_LEN; i++)
            if (digit_idx == IW'(i)) exp_digit = code[i];
    end

    lock_tick_gen #(.DIV(DIV), .TMAX(TMAX)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart ((state == ENTRY) || (state == PROG)),
        .limit   ((state == OPEN) ? LW'(TIMER1) : LW'(TIMER2)),
        .done    (done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ENTRY;
            z_r       <= 1'b0;
            seq_err   <= 1'b0;
            digit_idx <= '0;
            fail_cnt  <= '0;
            key_q     <= '1;
            key_d     <= '1;
            for (int i = 0; i < SEQ_LEN; i++)
                code[i] <= DW'(i % NKEYS);
        end else begin
            key_q <= bus.key;
            key_d <= key_q;
            case (state)
                ENTRY: begin
                    // Programming is only allowed from a clean idle point.
                    if (bus.passkey && fail_cnt == '0 && digit_idx == '0) begin
                        state <= PROG;
                    end else if (press) begin
                        if (last) begin
                            digit_idx <= '0;
                            seq_err   <= 1'b0;
                            if (!seq_err && !bad) begin
                                state    <= OPEN;
                                z_r      <= 1'b1;
                                fail_cnt <= '0;
                            end else if (fail_cnt == FW'(MAX_FAILS-1)) begin
                                state    <= LOCKOUT;
                                fail_cnt <= FW'(MAX_FAILS);
                            end else begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                        end else begin
                            digit_idx <= digit_idx + 1'b1;
                            if (bad) seq_err <= 1'b1;
                        end
                    end
                end
                PROG: begin
                    if (!bus.passkey) begin
                        state     <= ENTRY;
                        digit_idx <= '0;
                    end else if (press && valid) begin
                        for (int i = 0; i < SEQ_LEN; i++)
                            if (digit_idx == IW'(i)) code[i] <= digit;
                        digit_idx <= last ? '0 : digit_idx + 1'b1;
                    end
                end
                OPEN: begin
                    if (bus.passkey) begin
                        state <= PROG;
                        z_r   <= 1'b0;
                    end else if (done || relock) begin
                        state     <= ENTRY;
                        z_r       <= 1'b0;
                        digit_idx <= '0;
                    end
                end
                LOCKOUT: begin
                    if (done) begin
                        state    <= ENTRY;
                        fail_cnt <= '0;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

    always_comb begin
        led              = '0;
        led[LED_LOCKOUT] = (state == LOCKOUT);
        led[LED_PROG]    = (state == PROG);
        led[LED_Z]       = z_r;
        led[LED_ERR]     = seq_err;
    end

    assign bus.Z         = z_r;
    assign bus.Led       = led;
    assign bus.digit_idx = digit_idx;
    assign bus.fail_cnt  = fail_cnt;
endmodule

// File: tb/tb_seq_lock_n.sv
// tb_seq_lock_n: self-checking bench for seq_lock_n with a small
// configuration (4 keys, 4 digits, 2 failures, 3/2 tick windows, 4 clk/tick).
module tb_seq_lock_n;
    localparam int NK = 4, SL = 4, MF = 2, T1 = 3, T2 = 2, CF = 4, TH = 1;
    localparam int DIV = CF / TH;

    localparam int MD_ENTRY = 0, MD_PROG = 1, MD_OPEN = 2, MD_LOCK = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pk_g = 1'b0;

    seq_lock_n_if #(.NKEYS(NK), .SEQ_LEN(SL), .MAX_FAILS(MF)) bus ();

    seq_lock_n #(
        .NKEYS(NK), .SEQ_LEN(SL), .MAX_FAILS(MF), .TIMER1(T1), .TIMER2(T2),
        .CLK_FREQUENCY(CF), .TICK_HZ(TH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    int         mode;
    int         m_code [SL];
    int         entered [$];
    int         m_fail, prog_ptr, rem;
    logic [3:0] m_q, m_d;

    task automatic model_edge(input logic r, input logic [3:0] k, input logic pk);
        int  nz, dg;
        bit  pr, ok;
        if (!r) begin
            mode = MD_ENTRY;
            for (int i = 0; i < SL; i++) m_code[i] = i % NK;
            entered.delete();
            m_fail = 0; prog_ptr = 0; rem = 0;
            m_q = 4'hF; m_d = 4'hF;
            return;
        end
        nz = 0; dg = 0;
        for (int i = 0; i < NK; i++) if (!m_q[i]) begin nz++; dg = i; end
        pr = (m_d == 4'hF) && (m_q != 4'hF);
        m_d = m_q;
        m_q = k;
        case (mode)
            MD_ENTRY: begin
                if (pk && m_fail == 0 && entered.size() == 0) begin
                    mode = MD_PROG; prog_ptr = 0;
                end else if (pr) begin
                    entered.push_back((nz == 1) ? dg : -1);
                    if (entered.size() == SL) begin
                        ok = 1;
                        for (int i = 0; i < SL; i++) if (entered[i] != m_code[i]) ok = 0;
                        entered.delete();
                        if (ok) begin mode = MD_OPEN; rem = T1 * DIV; m_fail = 0; end
                        else if (m_fail + 1 == MF) begin mode = MD_LOCK; rem = T2 * DIV; m_fail = MF; end
                        else m_fail++;
                    end
                end
            end
            MD_PROG: begin
                if (!pk) mode = MD_ENTRY;
                else if (pr && nz == 1) begin
                    m_code[prog_ptr] = dg;
                    prog_ptr = (prog_ptr + 1) % SL;
                end
            end
            MD_OPEN: begin
                if (pk) begin mode = MD_PROG; prog_ptr = 0; end
                else begin
                    rem--;
                    if (rem == 0) mode = MD_ENTRY;
`ifdef SEQ_LOCK_KEY_RELOCK_EN
                    else if (pr && nz == 1) mode = MD_ENTRY;
`endif
                end
            end
            default: begin
                rem--;
                if (rem == 0) begin mode = MD_ENTRY; m_fail = 0; end
            end
        endcase
    endtask

    function automatic int m_err();
        if (mode != MD_ENTRY) return 0;
        for (int i = 0; i < entered.size(); i++) if (entered[i] != m_code[i]) return 1;
        return 0;
    endfunction

    function automatic int m_led();
        return ((mode == MD_LOCK) ? 8 : 0) + ((mode == MD_PROG) ? 4 : 0)
             + ((mode == MD_OPEN) ? 2 : 0) + m_err();
    endfunction

    function automatic int m_idx();
        if (mode == MD_ENTRY) return entered.size();
        if (mode == MD_PROG)  return prog_ptr;
        return 0;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] k, input logic pk);
        reset = r;
        bus.key = k;
        bus.passkey = pk;
        @(posedge clk);
        model_edge(r, k, pk);
        #1;
        check("model_Z", 32'(bus.Z), 32'(mode == MD_OPEN));
        check("model_Led", 32'(bus.Led), m_led());
        check("model_digit_idx", 32'(bus.digit_idx), m_idx());
        check("model_fail_cnt", 32'(bus.fail_cnt), m_fail);
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, k, pk_g);
        step(1'b1, 4'hF, pk_g);
    endtask

    function automatic logic [3:0] key_of(input int d);
        return 4'hF & ~(4'b0001 << d);
    endfunction

    typedef struct {
        logic       rst_n;
        logic [3:0] key;
        logic       pk;
        logic       z;
        logic [3:0] led;
        int         idx;
        int         fail;
    } vec_t;

    vec_t tv [$];

    task automatic add_vec(input logic r, input logic [3:0] k, input logic z,
                           input logic [3:0] led, input int idx);
        vec_t v;
        v.rst_n = r; v.key = k; v.pk = 1'b0; v.z = z; v.led = led; v.idx = idx; v.fail = 0;
        tv.push_back(v);
    endtask

    initial begin
        int lock_cnt;
        logic [3:0] k;
        logic r;
        int kr;

        bus.key = 4'hF;
        bus.passkey = 1'b0;

        // ---- table: default code unlocks, window is 12 cycles ----
        add_vec(1'b0, 4'hF, 1'b0, 4'h0, 0);
        add_vec(1'b1, 4'hE, 1'b0, 4'h0, 0);
        add_vec(1'b1, 4'hF, 1'b0, 4'h0, 1);
        add_vec(1'b1, 4'hD, 1'b0, 4'h0, 1);
        add_vec(1'b1, 4'hF, 1'b0, 4'h0, 2);
        add_vec(1'b1, 4'hB, 1'b0, 4'h0, 2);
        add_vec(1'b1, 4'hF, 1'b0, 4'h0, 3);
        add_vec(1'b1, 4'h7, 1'b0, 4'h0, 3);
        add_vec(1'b1, 4'hF, 1'b1, 4'h2, 0);
        for (int i = 0; i < 11; i++) add_vec(1'b1, 4'hF, 1'b1, 4'h2, 0);
        add_vec(1'b1, 4'hF, 1'b0, 4'h0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst_n, tv[i].key, tv[i].pk);
            check("tbl_Z", 32'(bus.Z), 32'(tv[i].z));
            check("tbl_Led", 32'(bus.Led), 32'(tv[i].led));
            check("tbl_idx", 32'(bus.digit_idx), tv[i].idx);
            check("tbl_fail", 32'(bus.fail_cnt), tv[i].fail);
        end

        // ---- programming a new code ----
        pk_g = 1'b1;
        step(1'b0, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        check("prog_led", 32'(bus.Led), 32'h4);
        press(4'h7); press(4'h7); press(4'hE); press(4'hD);
        check("prog_idx_wrap", 32'(bus.digit_idx), 0);
        pk_g = 1'b0;
        step(1'b1, 4'hF, 1'b0);
        press(4'h7); press(4'h7); press(4'hE); press(4'hD);
        check("prog_unlock", 32'(bus.Z), 1);
        for (int i = 0; i < 12; i++) step(1'b1, 4'hF, 1'b0);
        check("prog_window_end", 32'(bus.Z), 0);
        press(4'hE); press(4'hD); press(4'hB); press(4'h7);
        check("old_code_Z", 32'(bus.Z), 0);
        check("old_code_fail", 32'(bus.fail_cnt), 1);

        // ---- lockout ----
        step(1'b0, 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) press(4'hE);
        check("lock_led3", 32'(bus.Led[3]), 1);
        check("lock_fail", 32'(bus.fail_cnt), 2);
        lock_cnt = 1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, key_of(i), 1'b0);
            lock_cnt += int'(bus.Led[3]);
            step(1'b1, 4'hF, 1'b0);
            lock_cnt += int'(bus.Led[3]);
        end
        check("lock_len", 32'(lock_cnt), 8);
        check("lock_exit_fail", 32'(bus.fail_cnt), 0);
        check("lock_ignored_Z", 32'(bus.Z), 0);

        // ---- held key and multi-key press ----
        step(1'b0, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 4'hE, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        check("hold_idx", 32'(bus.digit_idx), 1);
        press(4'hC);
        check("multi_idx", 32'(bus.digit_idx), 2);
        check("multi_err", 32'(bus.Led[0]), 1);

        // ---- reset mid-sequence and during OPEN ----
        pk_g = 1'b1;
        step(1'b0, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) press(4'h7);
        pk_g = 1'b0;
        step(1'b1, 4'hF, 1'b0);
        press(4'hE); press(4'hD);
        check("mid_idx", 32'(bus.digit_idx), 2);
        step(1'b0, 4'hF, 1'b0);
        check("rst_idx", 32'(bus.digit_idx), 0);
        check("rst_led", 32'(bus.Led), 0);
        press(4'hE); press(4'hD); press(4'hB); press(4'h7);
        check("default_restored", 32'(bus.Z), 1);
        step(1'b0, 4'hF, 1'b0);
        check("rst_open_Z", 32'(bus.Z), 0);
        check("rst_open_idx", 32'(bus.digit_idx), 0);

`ifdef SEQ_LOCK_KEY_RELOCK_EN
        // ---- early relock by key press ----
        step(1'b1, 4'hF, 1'b0);
        press(4'hE); press(4'hD); press(4'hB); press(4'h7);
        check("relock_open", 32'(bus.Z), 1);
        step(1'b1, 4'hF, 1'b0);
        step(1'b1, 4'hE, 1'b0);
        check("relock_still_open", 32'(bus.Z), 1);
        step(1'b1, 4'hF, 1'b0);
        check("relock_Z", 32'(bus.Z), 0);
        check("relock_idx", 32'(bus.digit_idx), 0);
`endif

        // ---- randomized run against the model ----
        step(1'b0, 4'hF, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) < 2) pk_g = ~pk_g;
            kr = $urandom_range(0, 9);
            if (kr < 5) k = 4'hF;
            else if (kr < 8) k = (mode == MD_ENTRY) ? key_of(m_code[entered.size()])
                                                    : key_of($urandom_range(0, NK-1));
            else k = 4'($urandom);
            step(r, k, pk_g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
